// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width, counter sizing.
// Optional signed-overflow output is enabled with the SERIAL_SUB_OVF_EN macro.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// With SERIAL_SUB_OVF_EN defined the bundle also carries the ovf flag.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, busy, done_valid, diff, borrow_out, ovf
    );
    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, busy, done_valid, diff, borrow_out, ovf
    );
`else
    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, busy, done_valid, diff, borrow_out
    );
    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, busy, done_valid, diff, borrow_out
    );
`endif
endinterface

// File: rtl/serial_subtractor_one_bit_subtractor.sv
// One-bit full subtractor cell: diff = a - b - b_in, with borrow-out.
module one_bit_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);
    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~a & b_in) | (b & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_WL = cnt_width(WIDTH);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a_sh;
    logic [WIDTH-1:0]    r_b_sh;
    logic [WIDTH-1:0]    r_diff;
    logic                r_bin;
    logic                r_borrow;
    logic [CNT_WL-1:0]   r_cnt;

    logic                w_start_ready;
    logic                w_busy;
    logic                w_done_valid;
    logic                w_last;
    logic                w_d;
    logic                w_bout;

    one_bit_subtractor u_cell (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .b_in  (r_bin),
        .diff  (w_d),
        .b_out (w_bout)
    );

    assign w_last = (r_cnt == CNT_WL'(WIDTH - 1));

    always_comb begin
        w_state_next  = r_state;
        w_start_ready = 1'b0;
        w_busy        = 1'b0;
        w_done_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_ready = 1'b1;
                if (bus.start_valid) w_state_next = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                w_busy       = 1'b1;
                w_done_valid = 1'b1;
                if (bus.done_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && bus.start_valid) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (r_state == RUN && w_last) begin
            // The final cell output is the result MSB.
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    // r_a_sh doubles as the result register: each consumed minuend bit
    // frees the MSB slot that the new difference bit shifts into.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && bus.start_valid) begin
                r_a_sh <= bus.a;
                r_b_sh <= bus.b;
                r_bin  <= 1'b0;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_a_sh <= {w_d, r_a_sh[WIDTH-1:1]};
                r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_bin  <= w_bout;
                r_cnt  <= r_cnt + CNT_WL'(1);
                if (w_last) begin
                    r_diff   <= {w_d, r_a_sh[WIDTH-1:1]};
                    r_borrow <= w_bout;
                end
            end
        end
    end

    assign bus.start_ready = w_start_ready;
    assign bus.busy        = w_busy;
    assign bus.done_valid  = w_done_valid;
    assign bus.diff        = r_diff;
    assign bus.borrow_out  = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, scoreboard, corner sequences.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: integer subtraction and signed range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        int   r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa - sb;
        e.diff   = W'(int'(a) - int'(b));
        e.borrow = (a < b);
        e.ovf    = (r > 127) || (r < -128);
        return e;
    endfunction

    // Scoreboard consumer: one pop per accepted result.
    always @(negedge clk) begin
        if (bus.done_valid && bus.done_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got result %0h expected none", bus.diff);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("borrow", 32'(bus.borrow_out), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                $display("result diff=%0h borrow=%0b", bus.diff, bus.borrow_out);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.start_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.start_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        wait_ready("run_op");
        bus.a = a;
        bus.b = b;
        bus.start_valid = 1'b1;
        sb_q.push_back(e);
        $display("op a=%0h b=%0h", a, b);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        check("busy_run", 32'(bus.busy), 32'd1);
        check("ready_run", 32'(bus.start_ready), 32'd0);
        repeat (W - 1) @(posedge clk);
        #1;
        check("done_early", 32'(bus.done_valid), 32'd0);
        @(posedge clk); #1;
        check("done_latency", 32'(bus.done_valid), 32'd1);
        @(posedge clk); #1;
        check("back_idle", 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[9];
        exp_t e;
        int   last_hs;

        vecs[0] = '{8'd100,  8'd37,   8'd63,   1'b0, 1'b0};
        vecs[1] = '{8'd5,    8'd9,    8'hFC,   1'b1, 1'b0};
        vecs[2] = '{8'd0,    8'd0,    8'd0,    1'b0, 1'b0};
        vecs[3] = '{8'd0,    8'hFF,   8'd1,    1'b1, 1'b0};
        vecs[4] = '{8'h80,   8'h01,   8'h7F,   1'b0, 1'b1};
        vecs[5] = '{8'h10,   8'h20,   8'hF0,   1'b1, 1'b0};
        vecs[6] = '{8'hAA,   8'hAA,   8'h00,   1'b0, 1'b0};
        vecs[7] = '{8'hFF,   8'h00,   8'hFF,   1'b0, 1'b0};
        vecs[8] = '{8'h7F,   8'hFF,   8'h80,   1'b1, 1'b1};

        bus.start_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.done_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.start_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            e.diff   = vecs[i].diff;
            e.borrow = vecs[i].borrow;
            e.ovf    = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, e);
        end

        // Consumer stalls in DONE while start pulses must be ignored.
        wait_ready("hold");
        bus.done_ready = 1'b0;
        bus.a = 8'd200;
        bus.b = 8'd1;
        bus.start_valid = 1'b1;
        sb_q.push_back(model(8'd200, 8'd1));
        $display("op a=c8 b=1 with stalled consumer");
        @(posedge clk); #1;
        bus.a = 8'd7;
        bus.b = 8'd7;
        repeat (W) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            bus.start_valid = (k % 2 == 0);
            check("hold_done", 32'(bus.done_valid), 32'd1);
            check("hold_ready", 32'(bus.start_ready), 32'd0);
            check("hold_diff", 32'(bus.diff), 32'd199);
            check("hold_busy", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        bus.start_valid = 1'b0;
        bus.done_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_idle", 32'(bus.start_ready), 32'd1);
        check("hold_keep_diff", 32'(bus.diff), 32'd199);

        // Reset during RUN discards the in-flight result.
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.start_valid = 1'b1;
        $display("op a=aa b=55 aborted by reset");
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", 32'(bus.start_ready), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done_valid), 32'd0);
        check("mid_rst_diff", 32'(bus.diff), 32'd0);
        check("mid_rst_borrow", 32'(bus.borrow_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        e.diff = 8'd2;
        e.borrow = 1'b0;
        e.ovf = 1'b0;
        run_op(8'd3, 8'd1, e);

        // Back-to-back with start_valid held high.
        bus.start_valid = 1'b1;
        last_hs = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            wait_ready("b2b");
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            bus.a = ra;
            bus.b = rb;
            sb_q.push_back(model(ra, rb));
            $display("op a=%0h b=%0h", ra, rb);
            @(posedge clk); #1;
            if (i > 0) check("b2b_period", 32'(cyc - last_hs), 32'(W + 2));
            last_hs = cyc;
        end
        bus.start_valid = 1'b0;
        for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
